// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Contents: slot FSM state enum, slot length, segment-off pattern,
// BCD-to-segment decode and brightness clamp helpers.
package display_pkg;

    // Phase of the current digit slot.
    typedef enum logic [1:0] {
        ST_BLANK = 2'd0,
        ST_ON    = 2'd1,
        ST_DARK  = 2'd2
    } scan_state_e;

    // Sub-ticks per digit slot.
    localparam int unsigned SLOT_TICKS = 16;

    // All segments off (active-low).
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // BCD to active-low segments {g,f,e,d,c,b,a}; non-decimal codes blank the digit.
    function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
        logic [6:0] segs;
        case (bcd)
            4'd0:    segs = 7'b1000000;
            4'd1:    segs = 7'b1111001;
            4'd2:    segs = 7'b0100100;
            4'd3:    segs = 7'b0110000;
            4'd4:    segs = 7'b0011001;
            4'd5:    segs = 7'b0010010;
            4'd6:    segs = 7'b0000010;
            4'd7:    segs = 7'b1111000;
            4'd8:    segs = 7'b0000000;
            4'd9:    segs = 7'b0010000;
            default: segs = SEG_OFF;
        endcase
        return segs;
    endfunction

    // Limit requested on-time to what is left of the slot after blanking.
    function automatic logic [4:0] clamp_brightness(input logic [3:0] req,
                                                    input logic [4:0] limit);
        logic [4:0] req_w;
        req_w = {1'b0, req};
        return (req_w > limit) ? limit : req_w;
    endfunction

endpackage

// File: rtl/scan_tick_divider.sv
// Sub-tick prescaler: counts 0..PRESCALER and flags the terminal count.
// Latency: tick is combinational from the registered count (same clk).
// Backpressure: ena=0 freezes the count; tick is held low while frozen.
//
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   ena  - run enable
//   tick - high for one enabled clk at the end of every sub-tick
module scan_tick_divider #(
    parameter int unsigned PRESCALER = 99
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    output logic tick
);

    // PRESCALER=0 would give a zero-width counter; keep one bit that stays 0.
    localparam int unsigned  CW   = (PRESCALER > 0) ? $clog2(PRESCALER + 1) : 1;
    localparam logic [CW-1:0] TERM = CW'(PRESCALER);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = ena && (cnt_q == TERM);

    always_comb begin
        cnt_d = cnt_q;
        if (ena) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/display_scan_controller.sv
// Multiplexed 7-segment scan scheduler with per-slot blanking and PWM on-time.
// Latency: pins are registered; each sub-tick appears on the pins 1 clk after
//          the clk edge that presents it.
// Backpressure: ena=0 freezes all counters/FSM and blanks the pins.
//
// Ports:
//   clk, rst        - system clock, asynchronous active-low reset
//   ena             - run enable
//   digit_data      - 4-bit BCD per digit, digit i at [4i+3:4i], digit 0 rightmost
//   dp_mask         - decimal point request per digit
//   brightness      - on-time in sub-ticks per slot (0 = dark)
//   an              - active-low anode enables
//   seg             - active-low segments {g,f,e,d,c,b,a}
//   dp              - active-low decimal point
//   frame_start     - one-clk pulse when the digit-0 slot is first presented
module display_scan_controller #(
    parameter int unsigned NUM_DIGITS  = 6,
    parameter int unsigned PRESCALER   = 99,
    parameter int unsigned BLANK_TICKS = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic [4*NUM_DIGITS-1:0] digit_data,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [3:0]              brightness,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_start
);

    import display_pkg::*;

    localparam int unsigned   DW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DW-1:0] LAST_DIGIT = DW'(NUM_DIGITS - 1);
    localparam logic [3:0]    LAST_SUB   = 4'(SLOT_TICKS - 1);
    localparam logic [4:0]    BLANK_END  = 5'(BLANK_TICKS);
    localparam logic [4:0]    ON_LIMIT   = 5'(SLOT_TICKS - BLANK_TICKS);

    // ------------------------------------------------------------------
    // Position: prescaler (sub-module), sub-tick-in-slot s, digit index d
    // ------------------------------------------------------------------
    logic            tick;
    logic            sub_start_q;   // next enabled edge presents a fresh sub-tick
    logic [3:0]      s_q;
    logic [DW-1:0]   d_q;

    scan_tick_divider #(
        .PRESCALER (PRESCALER)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .ena  (ena),
        .tick (tick)
    );

    // The position registers always point at the sub-tick that the next
    // enabled edge will present, so the reset position (d=0, s=0) is the
    // first thing shown once scanning starts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sub_start_q <= 1'b1;
            s_q         <= '0;
            d_q         <= '0;
        end else begin
            if (ena) begin
                sub_start_q <= tick;
            end
            if (tick) begin
                s_q <= s_q + 4'd1;
                if (s_q == LAST_SUB) begin
                    d_q <= (d_q == LAST_DIGIT) ? '0 : d_q + 1'b1;
                end
            end
        end
    end

    // Edge that presents the first clk of a slot / of a frame.
    logic slot_first;
    logic frame_first;

    assign slot_first  = ena && sub_start_q && (s_q == 4'd0);
    assign frame_first = slot_first && (d_q == '0);

    // ------------------------------------------------------------------
    // Per-slot brightness and per-frame data snapshot
    // ------------------------------------------------------------------
    logic [4:0]              b_eff_q;
    logic [4:0]              b_slot;
    logic [4*NUM_DIGITS-1:0] snap_dat_q;
    logic [NUM_DIGITS-1:0]   snap_dp_q;
    logic [4*NUM_DIGITS-1:0] data_src;
    logic [NUM_DIGITS-1:0]   dp_src;

    // At the slot's first edge the live input is used directly, so a slot
    // with no blanking phase can light on its very first sub-tick.
    assign b_slot   = slot_first  ? clamp_brightness(brightness, ON_LIMIT) : b_eff_q;
    assign data_src = frame_first ? digit_data : snap_dat_q;
    assign dp_src   = frame_first ? dp_mask    : snap_dp_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            b_eff_q    <= '0;
            snap_dat_q <= '0;
            snap_dp_q  <= '0;
        end else begin
            if (slot_first) begin
                b_eff_q <= b_slot;
            end
            if (frame_first) begin
                snap_dat_q <= digit_data;
                snap_dp_q  <= dp_mask;
            end
        end
    end

    // ------------------------------------------------------------------
    // Slot FSM: evaluated once per sub-tick, on its first enabled edge
    // ------------------------------------------------------------------
    scan_state_e state_q;
    scan_state_e state_d;

    always_comb begin
        state_d = state_q;
        if (ena && sub_start_q) begin
            if (s_q == 4'd0) begin
                // Every slot re-enters here regardless of where the last one ended.
                if (BLANK_TICKS > 0) begin
                    state_d = ST_BLANK;
                end else begin
                    state_d = (b_slot != 5'd0) ? ST_ON : ST_DARK;
                end
            end else begin
                case (state_q)
                    ST_BLANK: begin
                        if ({1'b0, s_q} == BLANK_END) begin
                            state_d = (b_slot != 5'd0) ? ST_ON : ST_DARK;
                        end
                    end
                    ST_ON: begin
                        // Full-brightness slots never hit this; the wrap ends them.
                        if ({1'b0, s_q} == (BLANK_END + b_slot)) begin
                            state_d = ST_DARK;
                        end
                    end
                    default: state_d = state_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_BLANK;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Registered pins
    // ------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  fs_q, fs_d;
    logic [3:0]            cur_digit;
    logic                  lit;

    assign cur_digit = data_src[{d_q, 2'b00} +: 4];
    assign lit       = ena && (state_d == ST_ON);

    always_comb begin
        an_d  = '1;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        fs_d  = frame_first;
        if (lit) begin
            an_d[d_q] = 1'b0;
            seg_d     = seg_decode(cur_digit);
            dp_d      = ~dp_src[d_q];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an_q  <= '1;
            seg_q <= SEG_OFF;
            dp_q  <= 1'b1;
            fs_q  <= 1'b0;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
            fs_q  <= fs_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign frame_start = fs_q;

endmodule
